// File: rtl/ram_readback_verifier.sv
// Read-only sweep engine for a 128x16 async RAM: checks RAM[a] == seed - a over 0..LAST_ADRS.
// Optional feature: define RDBK_CHECKSUM_EN to add a running checksum output of all words read.
module ram_readback_verifier #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 16,
  parameter int LAST_ADRS = 127,
  parameter int WAIT_CYC  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic [ADDR_W-1:0] adrs,
  output logic              _ce,
  output logic              _we,
  output logic              _oe,
  input  logic [DATA_W-1:0] dataOut,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] first_err_adrs,
`ifdef RDBK_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic [DATA_W-1:0] first_err_data
);

  localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, WAIT, SAMPLE, FINISH} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   adrs_q, adrs_d;
  logic                en_n_q, en_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [7:0]          err_q, err_d;
  logic [ADDR_W-1:0]   fadr_q, fadr_d;
  logic [DATA_W-1:0]   fdat_q, fdat_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   expected;
  logic                mismatch;
`ifdef RDBK_CHECKSUM_EN
  logic [DATA_W-1:0]   csum_q, csum_d;
`endif

  assign expected = seed_q - DATA_W'(adrs_q);
  assign mismatch = (dataOut != expected);

  always_comb begin
    state_d = state_q;
    adrs_d  = adrs_q;
    en_n_d  = en_n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fadr_d  = fadr_q;
    fdat_d  = fdat_q;
    seed_d  = seed_q;
    cnt_d   = cnt_q;
`ifdef RDBK_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          seed_d  = seed;
          err_d   = '0;
          fadr_d  = '0;
          fdat_d  = '0;
          pass_d  = 1'b0;
          adrs_d  = '0;
          busy_d  = 1'b1;
          en_n_d  = 1'b0;
`ifdef RDBK_CHECKSUM_EN
          csum_d  = '0;
`endif
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = CW'(WAIT_CYC - 1);
        state_d = (WAIT_CYC > 1) ? WAIT : SAMPLE;
      end
      WAIT: begin
        if (cnt_q <= CW'(1)) state_d = SAMPLE;
        else                 cnt_d   = cnt_q - CW'(1);
      end
      SAMPLE: begin
        if (mismatch) begin
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          // err_q is still zero only on the first mismatch of the sweep
          if (err_q == 8'd0) begin
            fadr_d = adrs_q;
            fdat_d = dataOut;
          end
        end
`ifdef RDBK_CHECKSUM_EN
        csum_d = csum_q + dataOut;
`endif
        if (adrs_q == ADDR_W'(LAST_ADRS)) begin
          state_d = FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          en_n_d  = 1'b1;
          pass_d  = (err_d == 8'd0);
        end else begin
          adrs_d  = adrs_q + ADDR_W'(1);
          state_d = SETUP;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      adrs_q  <= '0;
      en_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fadr_q  <= '0;
      fdat_q  <= '0;
      seed_q  <= '0;
      cnt_q   <= '0;
`ifdef RDBK_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      adrs_q  <= adrs_d;
      en_n_q  <= en_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fadr_q  <= fadr_d;
      fdat_q  <= fdat_d;
      seed_q  <= seed_d;
      cnt_q   <= cnt_d;
`ifdef RDBK_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign adrs           = adrs_q;
  assign _ce            = en_n_q;
  assign _oe            = en_n_q;
  assign _we            = 1'b1;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_adrs = fadr_q;
  assign first_err_data = fdat_q;
`ifdef RDBK_CHECKSUM_EN
  assign checksum       = csum_q;
`endif

endmodule

// File: tb/tb_ram_readback_verifier.sv
// Self-checking bench: async RAM model plus a loop-based reference of the expected sweep results.
module tb_ram_readback_verifier;
  localparam int ADDR_W = 7, DATA_W = 16, LAST = 127, WAIT_CYC = 2;
  localparam int N = LAST + 1, SWEEP = N * (WAIT_CYC + 1);

  logic clk = 1'b0;
  logic rst, start;
  logic [DATA_W-1:0] seed, dataOut;
  logic [ADDR_W-1:0] adrs, first_err_adrs;
  logic ce_n, we_n, oe_n, busy, done, pass;
  logic [7:0] err_count;
  logic [DATA_W-1:0] first_err_data;
`ifdef RDBK_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  logic [DATA_W-1:0] ram [N];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    dataOut = 16'hDEAD;
    if (!ce_n && !oe_n) dataOut = ram[adrs];
  end

  ram_readback_verifier #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAST_ADRS(LAST), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .adrs(adrs),
    ._ce(ce_n), ._we(we_n), ._oe(oe_n), .dataOut(dataOut),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_adrs(first_err_adrs),
`ifdef RDBK_CHECKSUM_EN
    .checksum(checksum),
`endif
    .first_err_data(first_err_data)
  );

  // Reference: walk the RAM image and apply the rule RAM[a] == seed - a directly.
  task automatic model(input logic [DATA_W-1:0] s, output int e_err, output int e_fa,
                       output logic [DATA_W-1:0] e_fd, output logic [DATA_W-1:0] e_sum);
    logic [DATA_W-1:0] want;
    int raw;
    raw = 0; e_fa = 0; e_fd = '0; e_sum = '0;
    for (int a = 0; a < N; a++) begin
      want = s - DATA_W'(a);
      e_sum = e_sum + ram[a];
      if (ram[a] !== want) begin
        if (raw == 0) begin e_fa = a; e_fd = ram[a]; end
        raw++;
      end
    end
    e_err = (raw > 255) ? 255 : raw;
  endtask

  task automatic fill_pattern(input logic [DATA_W-1:0] s);
    for (int a = 0; a < N; a++) ram[a] = s - DATA_W'(a);
  endtask

  task automatic run_sweep(input logic [DATA_W-1:0] s, output int cyc, output int pulses, output bit we_low);
    cyc = -1; pulses = 0; we_low = 0;
    @(negedge clk); start = 1'b1; seed = s;
    @(negedge clk); start = 1'b0; seed = 16'($urandom);
    for (int n = 0; n < 4 * SWEEP; n++) begin
      if (we_n !== 1'b1) we_low = 1;
      if (done === 1'b1) begin
        pulses++;
        if (cyc < 0) cyc = n;
      end
      if (cyc >= 0 && n > cyc + 2) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; seed = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b want 0", pass); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err got %0d want 0", err_count); end
    checks++; if (adrs !== '0) begin errors++; $display("FAIL reset_adrs got %0d want 0", adrs); end
    checks++; if ({ce_n, we_n, oe_n} !== 3'b111) begin errors++; $display("FAIL reset_ctl got %b want 111", {ce_n, we_n, oe_n}); end
    checks++; if (first_err_adrs !== '0 || first_err_data !== '0) begin errors++;
      $display("FAIL reset_first got %0d/%h want 0/0000", first_err_adrs, first_err_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_sweep(input string name, input logic [DATA_W-1:0] s);
    int cyc, pulses, e_err, e_fa;
    bit we_low;
    logic [DATA_W-1:0] e_fd, e_sum;
    model(s, e_err, e_fa, e_fd, e_sum);
    run_sweep(s, cyc, pulses, we_low);
    checks++; if (cyc != SWEEP) begin errors++; $display("FAIL %s_latency got %0d want %0d", name, cyc, SWEEP); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL %s_done_width got %0d want 1", name, pulses); end
    checks++; if (we_low) begin errors++; $display("FAIL %s_we got low want always 1", name); end
    checks++; if (err_count !== 8'(e_err)) begin errors++; $display("FAIL %s_err got %0d want %0d", name, err_count, e_err); end
    checks++; if (pass !== (e_err == 0)) begin errors++; $display("FAIL %s_pass got %b want %b", name, pass, e_err == 0); end
    checks++; if (busy !== 1'b0 || ce_n !== 1'b1 || oe_n !== 1'b1) begin errors++;
      $display("FAIL %s_idle got busy=%b ce=%b oe=%b want 0 1 1", name, busy, ce_n, oe_n); end
    if (e_err != 0) begin
      checks++; if (first_err_adrs !== ADDR_W'(e_fa) || first_err_data !== e_fd) begin errors++;
        $display("FAIL %s_first got %0d/%h want %0d/%h", name, first_err_adrs, first_err_data, e_fa, e_fd); end
    end
`ifdef RDBK_CHECKSUM_EN
    checks++; if (checksum !== e_sum) begin errors++; $display("FAIL %s_checksum got %0d want %0d", name, checksum, e_sum); end
`endif
  endtask

  task automatic test_clean;       fill_pattern(16'd9804); check_sweep("clean", 16'd9804); endtask
  task automatic test_single_error; fill_pattern(16'd9804); ram[5] = 16'h0000; check_sweep("single", 16'd9804); endtask
  task automatic test_wrap;        fill_pattern(16'd3); check_sweep("wrap", 16'd3); endtask

  task automatic test_all_zero;
    for (int a = 0; a < N; a++) ram[a] = '0;
    check_sweep("allzero", 16'd9804);
  endtask

  task automatic test_checksum_ones;
    for (int a = 0; a < N; a++) ram[a] = 16'd1;
    check_sweep("ones", 16'd1);
  endtask

  task automatic test_random;
    logic [DATA_W-1:0] s;
    for (int it = 0; it < 5; it++) begin
      s = 16'($urandom);
      fill_pattern(s);
      for (int k = 0; k < int'($urandom_range(0, 6)); k++) ram[$urandom_range(0, LAST)] = 16'($urandom);
      check_sweep("random", s);
    end
  endtask

  task automatic test_reset_midsweep;
    int dn;
    bit hit;
    fill_pattern(16'd500);
    hit = 0;
    @(negedge clk); start = 1'b1; seed = 16'd500;
    @(negedge clk); start = 1'b0;
    for (int n = 0; n < 2 * SWEEP; n++) begin
      if (adrs == ADDR_W'(40)) begin hit = 1; break; end
      @(negedge clk);
    end
    checks++; if (!hit) begin errors++; $display("FAIL midrst_reach got adrs=%0d want 40", adrs); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || ce_n !== 1'b1 || oe_n !== 1'b1 || adrs !== '0 || done !== 1'b0) begin errors++;
      $display("FAIL midrst_state got busy=%b ce=%b oe=%b adrs=%0d done=%b want 0 1 1 0 0", busy, ce_n, oe_n, adrs, done); end
    rst = 1'b0;
    dn = 0;
    for (int n = 0; n < 2 * SWEEP; n++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dn++;
    end
    checks++; if (dn != 0) begin errors++; $display("FAIL midrst_quiet got %0d active cycles want 0", dn); end
  endtask

  task automatic test_start_while_busy;
    logic [ADDR_W-1:0] a0;
    bit seen;
    fill_pattern(16'd1000);
    @(negedge clk); start = 1'b1; seed = 16'd1000;
    @(negedge clk); start = 1'b0;
    repeat (50) @(negedge clk);
    a0 = adrs;
    start = 1'b1; seed = 16'h1234;
    @(negedge clk); start = 1'b0;
    checks++; if (busy !== 1'b1 || adrs < a0 || adrs == '0) begin errors++;
      $display("FAIL busy_start got busy=%b adrs=%0d want 1 and >=%0d", busy, adrs, a0); end
    seen = 0;
    for (int n = 0; n < 2 * SWEEP; n++) begin
      if (done === 1'b1) begin seen = 1; break; end
      @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL busy_done got none want pulse"); end
    start = 1'b1; seed = 16'd1000;
    @(negedge clk); start = 1'b0;
    checks++; if (pass !== 1'b1 || err_count !== 8'd0) begin errors++;
      $display("FAIL busy_seed got pass=%b err=%0d want 1 0", pass, err_count); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || ce_n !== 1'b1) begin errors++;
      $display("FAIL finish_start got busy=%b ce=%b want 0 1", busy, ce_n); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_error();
    test_wrap();
    test_all_zero();
    test_checksum_ones();
    test_random();
    test_reset_midsweep();
    test_start_while_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
